maxpool_stream: RTL

- Streaming 1-D max-pool stage that sits directly downstream of the convolution engine (conv_128_8_16_1: 128-sample input, 8-tap filter).
- Consumes the engine's ReLU'd signed output stream of NUM_IN points per frame over a valid/ready handshake.
- Emits the maximum of each non-overlapping window of WIN consecutive points, one result per window.
- A final partial window at frame end is pooled over the points actually present.

---
 rtl/maxpool_stream.sv | 103 ++++++++++
 1 files changed

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool: emits the signed maximum of each non-overlapping
// WIN-point window of a NUM_IN-point frame; a short final window is pooled as-is.
module maxpool_stream #(
    parameter int T      = 16,
    parameter int WIN    = 2,
    parameter int NUM_IN = 121
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] x_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [T-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                y_last
);

    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int FW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [WW-1:0] WLAST = WW'(WIN - 1);
    localparam logic [FW-1:0] FLAST = FW'(NUM_IN - 1);

    // Equal values keep the running maximum a.
    function automatic logic signed [T-1:0] smax(input logic signed [T-1:0] a,
                                                 input logic signed [T-1:0] b);
        return (b > a) ? b : a;
    endfunction

    logic signed [T-1:0] acc_q, acc_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic signed [T-1:0] y_data_q, y_data_d;
    logic                y_valid_q, y_valid_d;
    logic                y_last_q, y_last_d;

    logic                frame_end;
    logic                completing;
    logic                accept;
    logic                consume;
    logic signed [T-1:0] acc_new;

    always_comb begin
        frame_end  = (fcnt_q == FLAST);
        completing = (wcnt_q == WLAST) || frame_end;
        // Only a completing sample needs the output register free.
        x_ready    = reset && !(y_valid_q && !y_ready && completing);
        accept     = x_valid && x_ready;
        consume    = y_valid_q && y_ready;
        acc_new    = (wcnt_q == '0) ? x_data : smax(acc_q, x_data);
    end

    always_comb begin
        acc_d     = acc_q;
        wcnt_d    = wcnt_q;
        fcnt_d    = fcnt_q;
        y_data_d  = y_data_q;
        y_valid_d = y_valid_q;
        y_last_d  = y_last_q;

        if (consume) begin
            y_valid_d = 1'b0;
            y_last_d  = 1'b0;
        end

        if (accept) begin
            acc_d  = acc_new;
            fcnt_d = frame_end ? '0 : fcnt_q + 1'b1;
            if (completing) begin
                // A new result overrides a same-edge consume: no bubble.
                wcnt_d    = '0;
                y_data_d  = acc_new;
                y_valid_d = 1'b1;
                y_last_d  = frame_end;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            wcnt_q    <= '0;
            fcnt_q    <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            y_last_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            wcnt_q    <= wcnt_d;
            fcnt_q    <= fcnt_d;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            y_last_q  <= y_last_d;
        end
    end

    assign y_data  = y_data_q;
    assign y_valid = y_valid_q;
    assign y_last  = y_last_q;

endmodule
